// File: rtl/mem_access_unit_if.sv
// Bus bundle between the execute stage, mem_access_unit and rw_memory.
// The unit uses the slave modport; the execute stage / memory side uses master.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_enable;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_fault,
        output mem_enable, mem_write, mem_address, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
        input  mem_enable, mem_write, mem_address, mem_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store initiator for rw_memory; sub-word stores use read-modify-write.
// Optional ALIGN_CHECK_EN faults misaligned half/word accesses instead of ignoring low bits.
module mem_access_unit #(
    parameter int unsigned MEM_SIZE = 64000
) (
    input  logic              clk,
    input  logic              reset,
    mem_access_unit_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_e;

    state_e      state_q, state_d;
    logic        write_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] resp_rdata_q;
    logic        resp_fault_q;

    logic        ready;
    logic        accept;
    logic [32:0] last_byte;
    logic        range_bad;
    logic        align_bad;
    logic [31:0] byte_sh;
    logic [31:0] half_sh;
    logic [31:0] load_data;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;
    logic [31:0] merged;
    logic [31:0] rdata_d;
    logic        fault_d;

    // Ready is gated by reset so the execute stage sees no acceptance while reset is held.
    assign ready  = (state_q == IDLE) && reset;
    assign accept = bus.req_valid && ready;

    // 33-bit sum so addresses near 2^32 cannot wrap past the range check.
    assign last_byte = {1'b0, bus.req_addr[31:2], 2'b00} + 33'd3;
    assign range_bad = last_byte >= 33'(MEM_SIZE);

`ifdef ALIGN_CHECK_EN
    assign align_bad = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                       (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
`else
    assign align_bad = 1'b0;
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) begin
                if (range_bad || align_bad)                 state_d = DONE;
                else if (bus.req_write && bus.req_size[1])  state_d = WR;
                else                                        state_d = RD;
            end
            RD:      state_d = CAP;
            CAP:     state_d = write_q ? WR : DONE;
            WR:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        byte_sh = bus.mem_rdata >> {addr_q[1:0], 3'b000};
        half_sh = bus.mem_rdata >> {addr_q[1], 4'b0000};
        unique case (size_q)
            2'b00:   load_data = {{24{signed_q & byte_sh[7]}}, byte_sh[7:0]};
            2'b01:   load_data = {{16{signed_q & half_sh[15]}}, half_sh[15:0]};
            default: load_data = bus.mem_rdata;
        endcase

        if (size_q == 2'b00) begin
            lane_mask = 32'h0000_00FF << {addr_q[1:0], 3'b000};
            lane_data = {24'h0, wdata_q[7:0]} << {addr_q[1:0], 3'b000};
        end else begin
            lane_mask = 32'h0000_FFFF << {addr_q[1], 4'b0000};
            lane_data = {16'h0, wdata_q[15:0]} << {addr_q[1], 4'b0000};
        end
        merged = (bus.mem_rdata & ~lane_mask) | lane_data;

        rdata_d = ((state_q == CAP) && !write_q) ? load_data : 32'h0;
        fault_d = (state_q == IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            resp_rdata_q <= 32'h0;
            resp_fault_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            if (accept) begin
                write_q  <= bus.req_write;
                size_q   <= bus.req_size;
                signed_q <= bus.req_signed;
                addr_q   <= bus.req_addr;
                wdata_q  <= bus.req_wdata;
            end
            if ((state_q == CAP) && write_q)
                wdata_q <= merged;
            if (state_d == DONE) begin
                resp_rdata_q <= rdata_d;
                resp_fault_q <= fault_d;
            end
        end
    end

    assign bus.req_ready   = ready;
    assign bus.resp_valid  = (state_q == DONE);
    assign bus.resp_rdata  = resp_rdata_q;
    assign bus.resp_fault  = resp_fault_q;
    assign bus.mem_enable  = (state_q == RD) || (state_q == WR);
    assign bus.mem_write   = (state_q == WR);
    assign bus.mem_address = {addr_q[31:2], 2'b00};
    assign bus.mem_wdata   = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural rw_memory model.
// Build with +define+ALIGN_CHECK_EN to exercise the alignment-fault variant.
module tb_mem_access_unit;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_access_unit_if bus ();

    mem_access_unit #(.MEM_SIZE(64000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // rw_memory model: registered read data, write on enabled edge, clears the word if enabled in reset.
    logic [31:0] mem_model [int unsigned];
    logic [31:0] mem_rdata_q = 32'h0;
    assign bus.mem_rdata = mem_rdata_q;

    function automatic logic [31:0] get_mem(input logic [31:0] a);
        return mem_model.exists(a) ? mem_model[a] : 32'h0;
    endfunction

    always @(posedge clk) begin
        if (bus.mem_enable) begin
            if (!reset)             mem_model[bus.mem_address] = 32'h0;
            else if (bus.mem_write) mem_model[bus.mem_address] = bus.mem_wdata;
            else                    mem_rdata_q <= get_mem(bus.mem_address);
        end
    end

    int          n_en = 0, n_wr = 0, n_resp = 0, n_en_in_reset = 0;
    logic [31:0] last_wa = 32'h0, last_wd = 32'h0;
    always @(negedge clk) begin
        if (bus.mem_enable) n_en++;
        if (bus.mem_enable && !reset) n_en_in_reset++;
        if (bus.mem_enable && bus.mem_write) begin
            n_wr++;
            last_wa = bus.mem_address;
            last_wd = bus.mem_wdata;
        end
        if (bus.resp_valid) n_resp++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request from #1 after a rising edge; returns at #1 after a rising edge.
    task automatic do_req(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_f,
                          input int exp_lat, input int exp_en, input int exp_wr);
        int en0, wr0, lat, guard;
        bit seen;
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check({tag, " ready"}, 32'(bus.req_ready), 32'd1);
        en0 = n_en;
        wr0 = n_wr;
        bus.req_write  = wr;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
        @(posedge clk); #1;
        // Fields change after acceptance; the unit must not care.
        bus.req_valid  = 1'b0;
        bus.req_write  = ~wr;
        bus.req_size   = ~sz;
        bus.req_signed = ~sg;
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        lat  = 1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.resp_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, seen ? 32'(lat) : 32'hFFFF_FFFF, 32'(exp_lat));
        check({tag, " rdata"}, bus.resp_rdata, exp_rd);
        check({tag, " fault"}, 32'(bus.resp_fault), 32'(exp_f));
        @(posedge clk); #1;
        check({tag, " pulse"}, 32'(bus.resp_valid), 32'd0);
        check({tag, " rdata hold"}, bus.resp_rdata, exp_rd);
        check({tag, " enables"}, 32'(n_en - en0), 32'(exp_en));
        check({tag, " writes"}, 32'(n_wr - wr0), 32'(exp_wr));
    endtask

    int wr0, resp0;

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        mem_model[32'd63996] = 32'h0BAD_F00D;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst ready", 32'(bus.req_ready), 32'd0);
        check("rst enable", 32'(bus.mem_enable), 32'd0);
        check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst rdata", bus.resp_rdata, 32'h0);
        check("rst fault", 32'(bus.resp_fault), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst release ready", 32'(bus.req_ready), 32'd1);

        // 1: word store then word load
        do_req("st_w", 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1, 1);
        check("st_w addr", last_wa, 32'h100);
        check("st_w data", last_wd, 32'hDEAD_BEEF);
        do_req("ld_w", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 1, 0);

        // 2: byte store by read-modify-write, then byte loads
        do_req("st_b", 1'b1, 2'b00, 1'b0, 32'h102, 32'hAAAA_AA55, 32'h0, 1'b0, 4, 2, 1);
        check("st_b addr", last_wa, 32'h100);
        check("st_b data", last_wd, 32'hDE55_BEEF);
        do_req("ld_sb2", 1'b0, 2'b00, 1'b1, 32'h102, 32'h0, 32'h0000_0055, 1'b0, 3, 1, 0);
        do_req("ld_sb3", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'hFFFF_FFDE, 1'b0, 3, 1, 0);

        // 3: half loads and half store
        do_req("st_w2", 1'b1, 2'b10, 1'b0, 32'h100, 32'h8001_BEEF, 32'h0, 1'b0, 2, 1, 1);
        do_req("ld_uh", 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h0000_8001, 1'b0, 3, 1, 0);
        do_req("ld_sh", 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'hFFFF_8001, 1'b0, 3, 1, 0);
        do_req("st_h", 1'b1, 2'b01, 1'b0, 32'h100, 32'hFFFF_1234, 32'h0, 1'b0, 4, 2, 1);
        check("st_h data", last_wd, 32'h8001_1234);
        check("st_h mem", get_mem(32'h100), 32'h8001_1234);
        do_req("ld_ub3", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h0000_0080, 1'b0, 3, 1, 0);
        do_req("ld_sb3b", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'hFFFF_FF80, 1'b0, 3, 1, 0);

        // 4: range boundary
        do_req("ld_range", 1'b0, 2'b10, 1'b0, 32'd64000, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        do_req("ld_last", 1'b0, 2'b10, 1'b0, 32'd63996, 32'h0, 32'h0BAD_F00D, 1'b0, 3, 1, 0);
        do_req("st_wrap", 1'b1, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h1111_1111, 32'h0, 1'b1, 1, 0, 0);

        // 5: misaligned word load
`ifdef ALIGN_CHECK_EN
        do_req("ld_misal", 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h0, 1'b1, 1, 0, 0);
`else
        do_req("ld_misal", 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h8001_1234, 1'b0, 3, 1, 0);
`endif

        // 6: reset during CAP of a byte store
        wr0   = n_wr;
        resp0 = n_resp;
        bus.req_write  = 1'b1;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h101;
        bus.req_wdata  = 32'h77;
        bus.req_valid  = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("abort enable", 32'(bus.mem_enable), 32'd0);
        check("abort ready", 32'(bus.req_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort ready after", 32'(bus.req_ready), 32'd1);
        check("abort writes", 32'(n_wr - wr0), 32'd0);
        check("abort resp", 32'(n_resp - resp0), 32'd0);
        check("abort mem", get_mem(32'h100), 32'h8001_1234);
        check("abort enable in reset", 32'(n_en_in_reset), 32'd0);
        do_req("ld_post", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h8001_1234, 1'b0, 3, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
